// File: rtl/csa_accum_ctrl_pkg.sv
// Shared definitions for the carry-save accumulator controller:
// default widths and the FSM state encoding.
package csa_accum_ctrl_pkg;
   localparam int W_DEF  = 32;
   localparam int CW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      OUTPUT  = 2'd3
   } state_t;
endpackage

// File: rtl/csa_accum_ctrl_compressor.sv
// Combinational n-bit 4-2 compressor: a+b+c+d = sum + 2*carry + 2^n*cout.
// Built from two chained full adders per bit; the first stage's carry ripples one bit only.
module Compressor_4_2 #(
   parameter int n = 32
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic [n-1:0] c,
   input  logic [n-1:0] d,
   output logic [n-1:0] sum,
   output logic [n-1:0] carry,
   output logic         cout
);
   logic [n:0] chain;

   assign chain[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < n; gi++) begin : g_bit
         logic s1;
         assign s1            = a[gi] ^ b[gi] ^ c[gi];
         assign chain[gi + 1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
         assign sum[gi]       = s1 ^ d[gi] ^ chain[gi];
         assign carry[gi]     = (s1 & d[gi]) | (s1 & chain[gi]) | (d[gi] & chain[gi]);
      end
   endgenerate

   assign cout = chain[n];
endmodule

// File: rtl/csa_accum_ctrl.sv
// Packet accumulator: two operands per beat folded into a carry-save (S,C) pair,
// resolved with a single CPA cycle and presented on a valid/ready result port.
module csa_accum_ctrl
   import csa_accum_ctrl_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_op0,
   input  logic [W-1:0]  in_op1,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_sum,
   output logic [CW-1:0] out_beats,
   output logic          busy
);
   state_t        state_q, state_d;
   logic [W-1:0]  s_q, s_d;
   logic [W-1:0]  c_q, c_d;
   logic [W-1:0]  sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;

   logic [W-1:0]  c_shift;
   logic [W-1:0]  comp_sum;
   logic [W-1:0]  comp_carry;
   logic          comp_cout;
   logic          accept;
   logic [CW-1:0] cnt_inc;
   logic          unused_bits;

   // C[i] carries weight 2^(i+1); the top bit falls off the modulo-2^W result.
   assign c_shift     = {c_q[W-2:0], 1'b0};
   assign unused_bits = comp_cout ^ c_q[W-1];

   Compressor_4_2 #(.n(W)) u_comp (
      .a     (in_op0),
      .b     (in_op1),
      .c     (s_q),
      .d     (c_shift),
      .sum   (comp_sum),
      .carry (comp_carry),
      .cout  (comp_cout)
   );

   assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
   assign accept    = in_valid && in_ready && !flush;
   assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_beats = cnt_q;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      c_d         = c_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         state_d     = IDLE;
         s_d         = '0;
         c_d         = '0;
         sum_d       = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  s_d     = comp_sum;
                  c_d     = comp_carry;
                  cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_inc;
                  state_d = in_last ? RESOLVE : ACCUM;
               end
            end
            RESOLVE: begin
               sum_d       = s_q + c_shift;
               out_valid_d = 1'b1;
               state_d     = OUTPUT;
            end
            OUTPUT: begin
               if (out_ready) begin
                  s_d         = '0;
                  c_d         = '0;
                  cnt_d       = '0;
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         s_q         <= '0;
         c_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: a packet-level model checked every cycle,
// plus literal expectations on each result.
module tb_csa_accum_ctrl;
   localparam int W  = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_op0;
   logic [W-1:0]  in_op1;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic [CW-1:0] out_beats;
   logic          busy;

   int total = 0;
   int bad   = 0;

   csa_accum_ctrl #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op0    (in_op0),
      .in_op1    (in_op1),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_beats (out_beats),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Packet-level model: phase 0 collects beats, 1 resolves, 2 presents the result.
   int            m_phase;
   longint        m_acc;
   int            m_cnt;
   logic [W-1:0]  m_res_sum;
   int            m_res_beats;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase     <= 0;
         m_acc       <= 0;
         m_cnt       <= 0;
         m_res_sum   <= '0;
         m_res_beats <= 0;
      end else if (flush) begin
         m_phase <= 0;
         m_acc   <= 0;
         m_cnt   <= 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               m_acc <= (m_acc + longint'(in_op0) + longint'(in_op1)) % 64'h1_0000_0000;
               m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
               if (in_last) m_phase <= 1;
            end
            1: begin
               m_res_sum   <= m_acc[W-1:0];
               m_res_beats <= m_cnt;
               m_phase     <= 2;
            end
            default: if (out_ready) begin
               m_phase <= 0;
               m_acc   <= 0;
               m_cnt   <= 0;
            end
         endcase
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", W'(in_ready), W'(m_phase == 0));
         check("out_valid", W'(out_valid), W'(m_phase == 2));
         check("busy", W'(busy), W'((m_phase != 0) || (m_cnt != 0)));
         if (m_phase == 2) begin
            check("model_sum", out_sum, m_res_sum);
            check("model_beats", W'(out_beats), W'(m_res_beats));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
      in_valid = 1'b1;
      in_op0   = a;
      in_op1   = b;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(input string name, input logic [W-1:0] exp_sum, input int exp_beats);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      if (!out_valid) begin
         check({name, "_timeout"}, W'(out_valid), W'(1));
      end else begin
         check({name, "_sum"}, out_sum, exp_sum);
         check({name, "_beats"}, W'(out_beats), W'(exp_beats));
         $display("result %s: sum=%0h beats=%0d", name, out_sum, out_beats);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check({name, "_idle"}, W'(busy), W'(0));
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op0 = '0; in_op1 = '0;
      in_last = 1'b0; out_ready = 1'b0;
      step();
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_out_sum", out_sum, W'(0));
      check("rst_out_beats", W'(out_beats), W'(0));
      rst = 1'b0;
      step();

      // 1: single beat, exact two-cycle latency
      beat(32'd5, 32'd7, 1'b1);
      check("t1_resolve_valid", W'(out_valid), W'(0));
      check("t1_resolve_ready", W'(in_ready), W'(0));
      step();
      check("t1_latency", W'(out_valid), W'(1));
      wait_result("t1", 32'd12, 1);

      // 2: wrap-around modulo 2^W
      beat(32'd1, 32'd2, 1'b0);
      beat(32'd3, 32'd4, 1'b0);
      beat(32'hFFFF_FFFF, 32'd1, 1'b1);
      wait_result("t2", 32'h0000_000A, 3);

      // 3: backpressure holds the result stable
      beat(32'd2, 32'd3, 1'b1);
      step();
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", W'(out_valid), W'(1));
         check("t3_hold_sum", out_sum, 32'd5);
         check("t3_hold_ready", W'(in_ready), W'(0));
         step();
      end
      wait_result("t3", 32'd5, 1);

      // 4: flush drops the partial packet and the same-cycle beat
      beat(32'd8, 32'd8, 1'b0);
      beat(32'd8, 32'd8, 1'b0);
      flush = 1'b1;
      beat(32'd100, 32'd100, 1'b0);
      flush = 1'b0;
      check("t4_flush_busy", W'(busy), W'(0));
      beat(32'd9, 32'd1, 1'b1);
      wait_result("t4", 32'd10, 1);

      // 5: asynchronous reset during RESOLVE
      beat(32'd4, 32'd4, 1'b1);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", W'(out_valid), W'(0));
      check("t5_rst_busy", W'(busy), W'(0));
      step();
      rst = 1'b0;
      step();
      beat(32'd20, 32'd22, 1'b1);
      wait_result("t5", 32'd42, 1);

      // 6: long packet with gaps, counter saturates
      for (int i = 0; i < 300; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step();
         beat(32'd1, 32'd0, (i == 299));
      end
      wait_result("t6", 32'd300, 255);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
